// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer for the fetch stage: latches a request, waits for
// in-flight control flow to drain, injects push-PC / push-flags / load-vector,
// and blocks re-entry until the handler's RTI retires.
module interrupt_sequencer #(
  parameter int                     INSTR_WIDTH   = 16,
  parameter logic [INSTR_WIDTH-1:0] OP_PUSH_PC    = 16'hE000,
  parameter logic [INSTR_WIDTH-1:0] OP_PUSH_FLAGS = 16'hE400,
  parameter logic [INSTR_WIDTH-1:0] OP_LOAD_VEC   = 16'hE800,
  parameter int                     DRAIN_CYCLES  = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_interrupt_call,
  input  logic                   i_stall,
  input  logic                   i_branch_inflight,
  input  logic                   i_rti_retired,
  output logic                   o_inject,
  output logic [INSTR_WIDTH-1:0] o_inject_instr,
  output logic                   o_fetch_hold,
  output logic                   o_hold_enable,
  output logic                   o_in_service,
  output logic                   o_pending
);

  localparam int               CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_INJ_PC,
    S_INJ_FLAGS,
    S_INJ_VEC,
    S_SERVICE
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pending;
  logic                   r_inject;
  logic [INSTR_WIDTH-1:0] r_inject_instr;
  logic                   r_fetch_hold;
  logic                   r_hold_enable;
  logic                   r_in_service;

  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_pending_next;
  logic                   w_inject;
  logic [INSTR_WIDTH-1:0] w_inject_instr;
  logic                   w_fetch_hold;
  logic                   w_hold_enable;
  logic                   w_in_service;

  // Next-state, drain counter and pending-request logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;

    // A request arriving while already busy is remembered one deep.
    if (r_state != S_IDLE && i_interrupt_call) begin
      w_pending_next = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_interrupt_call || r_pending) begin
          w_state_next   = S_DRAIN;
          w_cnt_next     = '0;
          w_pending_next = 1'b0;
        end
      end
      S_DRAIN: begin
        if (i_branch_inflight) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_INJ_PC;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_INJ_PC:    if (!i_stall) w_state_next = S_INJ_FLAGS;
      S_INJ_FLAGS: if (!i_stall) w_state_next = S_INJ_VEC;
      S_INJ_VEC:   if (!i_stall) w_state_next = S_SERVICE;
      S_SERVICE:   if (i_rti_retired) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Output decode of the next state, so the registered outputs line up with r_state.
  always_comb begin
    w_inject       = 1'b0;
    w_inject_instr = '0;
    w_fetch_hold   = 1'b0;
    w_hold_enable  = 1'b0;
    w_in_service   = 1'b0;
    case (w_state_next)
      S_IDLE:      w_hold_enable = 1'b1;
      S_DRAIN:     w_fetch_hold  = 1'b1;
      S_INJ_PC: begin
        w_inject       = 1'b1;
        w_fetch_hold   = 1'b1;
        w_inject_instr = OP_PUSH_PC;
      end
      S_INJ_FLAGS: begin
        w_inject       = 1'b1;
        w_fetch_hold   = 1'b1;
        w_inject_instr = OP_PUSH_FLAGS;
      end
      S_INJ_VEC: begin
        w_inject       = 1'b1;
        w_fetch_hold   = 1'b1;
        w_inject_instr = OP_LOAD_VEC;
      end
      S_SERVICE:   w_in_service  = 1'b1;
      default:     w_hold_enable = 1'b0;
    endcase
  end

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      r_inject       <= 1'b0;
      r_inject_instr <= '0;
      r_fetch_hold   <= 1'b0;
      r_hold_enable  <= 1'b1;
      r_in_service   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_pending      <= w_pending_next;
      r_inject       <= w_inject;
      r_inject_instr <= w_inject_instr;
      r_fetch_hold   <= w_fetch_hold;
      r_hold_enable  <= w_hold_enable;
      r_in_service   <= w_in_service;
    end
  end

  assign o_inject       = r_inject;
  assign o_inject_instr = r_inject_instr;
  assign o_fetch_hold   = r_fetch_hold;
  assign o_hold_enable  = r_hold_enable;
  assign o_in_service   = r_in_service;
  assign o_pending      = r_pending;

endmodule
